mfp_ahb_portctrl: RTL and testbench



---
 rtl/mfp_portctrl_pkg.sv | 21 ++
 rtl/mfp_port_channel.sv | 53 +++++
 rtl/mfp_ahb_portctrl.sv | 141 ++++++++++++++
 tb/tb_mfp_ahb_portctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_portctrl_pkg.sv
// Shared register map and limits for the AHB port-control slave.
// The offsets are byte offsets; the decode compares word indices.
package mfp_portctrl_pkg;

    localparam int MAX_N_CH   = 8;
    localparam int MAX_N_CTRL = 4;

    localparam logic [7:0] OFS_CH_DATA = 8'h00;
    localparam logic [7:0] OFS_PENDING = 8'h20;
    localparam logic [7:0] OFS_MASK    = 8'h24;
    localparam logic [7:0] OFS_ACK     = 8'h28;
    localparam logic [7:0] OFS_OVERRUN = 8'h2C;
    localparam logic [7:0] OFS_CTRL    = 8'h30;

    localparam logic [2:0] SIZE_WORD = 3'b010;

    function automatic logic [5:0] word_idx(input logic [7:0] ofs);
        return ofs[7:2];
    endfunction

endpackage

// File: rtl/mfp_port_channel.sv
// One capture channel: update-edge detect, data register, pending/overrun
// flags and the acknowledge pulse returned to the peripheral.
module mfp_port_channel #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          updt,
    input  logic [DW-1:0] info,
    input  logic          clear,
    input  logic          ovr_clr,
    output logic [DW-1:0] data,
    output logic          pending,
    output logic          pending_d,
    output logic          overrun_d,
    output logic          intack
);

    logic updt_q;
    logic overrun;
    logic capture;

    assign capture = updt & ~updt_q;

    // A capture beats a clear on the same edge; an overrun set beats its W1C.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        pending_d = pending;
        overrun_d = overrun;
        if (clear)   pending_d = 1'b0;
        if (capture) pending_d = 1'b1;
        if (ovr_clr) overrun_d = 1'b0;
        if (capture && pending && !clear) overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        // Tracks the strobe even in reset, so a level held through reset is not an edge.
        // NOTE: state uses <= so every flop samples the pre-edge values.
        updt_q <= updt;
        if (rst) begin
            data    <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
            intack  <= 1'b0;
        end else begin
            if (capture) data <= info;
            pending <= pending_d;
            overrun <= overrun_d;
            intack  <= clear & pending & ~capture;
        end
    end

endmodule

// File: rtl/mfp_ahb_portctrl.sv
// AHB-Lite slave with N capture channels, M control ports, pending/overrun
// flags, an interrupt mask and a registered IRQ. Zero wait states.
module mfp_ahb_portctrl
    import mfp_portctrl_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DW     = 32,
    parameter int N_CTRL = 2,
    parameter int CTRL_W = 8
) (
    input  logic                     HCLK,
    input  logic                     SI_Reset,
    input  logic                     HSEL,
    input  logic [7:0]               HADDR,
    input  logic [1:0]               HTRANS,
    input  logic                     HWRITE,
    input  logic [2:0]               HSIZE,
    input  logic [31:0]              HWDATA,
    input  logic                     HREADY,
    output logic [31:0]              HRDATA,
    output logic                     HREADYOUT,
    output logic                     HRESP,
    input  logic [N_CH*DW-1:0]       PORT_INFO,
    input  logic [N_CH-1:0]          PORT_UPDT,
    output logic [N_CH-1:0]          PORT_INTACK,
    output logic [N_CTRL*CTRL_W-1:0] PORT_CTRL,
    output logic                     IRQ
);

    logic              acc;
    logic              rd_acc;
    logic [5:0]        rd_idx;
    logic [5:0]        rd_ch_ofs;
    logic [5:0]        rd_ctrl_ofs;
    logic              wr_q;
    logic              word_q;
    logic [5:0]        widx_q;
    logic              wr_en;
    logic [N_CH-1:0]   ch_clear;
    logic [N_CH-1:0]   ovr_clr;
    logic [N_CH-1:0]   pending_q;
    logic [N_CH-1:0]   pending_d;
    logic [N_CH-1:0]   overrun_d;
    logic [DW-1:0]     ch_data [N_CH];
    logic [N_CH-1:0]   mask_q;
    logic [N_CH-1:0]   mask_d;
    logic [CTRL_W-1:0] ctrl_q [N_CTRL];
    logic [CTRL_W-1:0] ctrl_d [N_CTRL];
    logic [31:0]       rd_data;
    logic              unused;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign unused    = &{1'b0, HADDR[1:0], HTRANS[0], HWDATA};

    assign acc         = HSEL & HTRANS[1] & HREADY;
    assign rd_acc      = acc & ~HWRITE;
    assign rd_idx      = HADDR[7:2];
    assign rd_ch_ofs   = rd_idx - word_idx(OFS_CH_DATA);
    assign rd_ctrl_ofs = rd_idx - word_idx(OFS_CTRL);
    assign wr_en       = wr_q & word_q;

    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            wr_q   <= 1'b0;
            word_q <= 1'b0;
            widx_q <= '0;
        end else begin
            wr_q <= acc & HWRITE;
            if (acc) begin
                word_q <= (HSIZE == SIZE_WORD);
                widx_q <= HADDR[7:2];
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        mfp_port_channel #(.DW(DW)) u_ch (
            .clk       (HCLK),
            .rst       (SI_Reset),
            .updt      (PORT_UPDT[i]),
            .info      (PORT_INFO[i*DW +: DW]),
            .clear     (ch_clear[i]),
            .ovr_clr   (ovr_clr[i]),
            .data      (ch_data[i]),
            .pending   (pending_q[i]),
            .pending_d (pending_d[i]),
            .overrun_d (overrun_d[i]),
            .intack    (PORT_INTACK[i])
        );
    end

    // Clears come from a read in its address phase or an ACK write in its data phase.
    always_comb begin
        ch_clear = '0;
        ovr_clr  = '0;
        for (int i = 0; i < N_CH; i++)
            if (rd_acc && rd_ch_ofs < 6'(MAX_N_CH) && rd_ch_ofs == 6'(i)) ch_clear[i] = 1'b1;
        if (wr_en && widx_q == word_idx(OFS_ACK))     ch_clear = ch_clear | HWDATA[N_CH-1:0];
        if (wr_en && widx_q == word_idx(OFS_OVERRUN)) ovr_clr  = HWDATA[N_CH-1:0];
    end

    always_comb begin
        mask_d = mask_q;
        ctrl_d = ctrl_q;
        if (wr_en && widx_q == word_idx(OFS_MASK)) mask_d = HWDATA[N_CH-1:0];
        for (int j = 0; j < N_CTRL; j++)
            if (wr_en && widx_q == word_idx(OFS_CTRL) + 6'(j)) ctrl_d[j] = HWDATA[CTRL_W-1:0];
    end

    // Read mux looks at next-state values so a read right after a write sees it.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_CH; i++)
            if (rd_ch_ofs < 6'(MAX_N_CH) && rd_ch_ofs == 6'(i)) rd_data[DW-1:0] = ch_data[i];
        for (int j = 0; j < N_CTRL; j++)
            if (rd_ctrl_ofs < 6'(MAX_N_CTRL) && rd_ctrl_ofs == 6'(j)) rd_data[CTRL_W-1:0] = ctrl_d[j];
        if (rd_idx == word_idx(OFS_PENDING)) rd_data[N_CH-1:0] = pending_d;
        if (rd_idx == word_idx(OFS_MASK))    rd_data[N_CH-1:0] = mask_d;
        if (rd_idx == word_idx(OFS_OVERRUN)) rd_data[N_CH-1:0] = overrun_d;
    end

    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            mask_q <= '0;
            ctrl_q <= '{default: '0};
            HRDATA <= '0;
            IRQ    <= 1'b0;
        end else begin
            mask_q <= mask_d;
            ctrl_q <= ctrl_d;
            HRDATA <= rd_acc ? rd_data : 32'h0;
            IRQ    <= |(pending_q & mask_q);
        end
    end

    for (genvar j = 0; j < N_CTRL; j++) begin : g_ctrl
        assign PORT_CTRL[j*CTRL_W +: CTRL_W] = ctrl_q[j];
    end

endmodule

// File: tb/tb_mfp_ahb_portctrl.sv
// Self-checking bench for mfp_ahb_portctrl: read expectations go into a
// scoreboard queue at the address phase and are popped in the data phase.
module tb_mfp_ahb_portctrl;

    localparam int N_CH   = 4;
    localparam int DW     = 32;
    localparam int N_CTRL = 2;
    localparam int CTRL_W = 8;

    logic                     HCLK = 1'b0;
    logic                     SI_Reset;
    logic                     HSEL;
    logic [7:0]               HADDR;
    logic [1:0]               HTRANS;
    logic                     HWRITE;
    logic [2:0]               HSIZE;
    logic [31:0]              HWDATA;
    logic                     HREADY;
    logic [31:0]              HRDATA;
    logic                     HREADYOUT;
    logic                     HRESP;
    logic [N_CH*DW-1:0]       PORT_INFO;
    logic [N_CH-1:0]          PORT_UPDT;
    logic [N_CH-1:0]          PORT_INTACK;
    logic [N_CTRL*CTRL_W-1:0] PORT_CTRL;
    logic                     IRQ;

    int n_run  = 0;
    int n_fail = 0;

    logic [31:0] exp_q [$];
    string       name_q [$];

    mfp_ahb_portctrl #(.N_CH(N_CH), .DW(DW), .N_CTRL(N_CTRL), .CTRL_W(CTRL_W)) dut (
        .HCLK        (HCLK),
        .SI_Reset    (SI_Reset),
        .HSEL        (HSEL),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HWDATA      (HWDATA),
        .HREADY      (HREADY),
        .HRDATA      (HRDATA),
        .HREADYOUT   (HREADYOUT),
        .HRESP       (HRESP),
        .PORT_INFO   (PORT_INFO),
        .PORT_UPDT   (PORT_UPDT),
        .PORT_INTACK (PORT_INTACK),
        .PORT_CTRL   (PORT_CTRL),
        .IRQ         (IRQ)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HSIZE  = 3'b010;
    endtask

    task automatic sb_check();
        logic [31:0] e;
        string       n;
        n_run++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_underflow: HRDATA got %h with nothing expected", HRDATA);
        end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (HRDATA !== e) begin
                n_fail++;
                $display("FAIL %s: HRDATA got %h want %h", n, HRDATA, e);
            end
        end
    endtask

    task automatic ahb_read(input logic [7:0] addr, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr; HSIZE = 3'b010;
        step();
        bus_idle();
        sb_check();
    endtask

    task automatic ahb_write(input logic [7:0] addr, input logic [31:0] data, input logic [2:0] size);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr; HSIZE = size;
        step();
        bus_idle();
        HWDATA = data;
        step();
    endtask

    task automatic write_then_read(input logic [7:0] waddr, input logic [31:0] wdata,
                                   input logic [2:0] wsize, input logic [7:0] raddr,
                                   input logic [31:0] exp, input string name);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = waddr; HSIZE = wsize;
        step();
        HWDATA = wdata; HWRITE = 1'b0; HADDR = raddr; HSIZE = 3'b010;
        exp_q.push_back(exp);
        name_q.push_back(name);
        step();
        bus_idle();
        sb_check();
    endtask

    task automatic pulse_updt(input int ch, input logic [31:0] value);
        PORT_INFO[ch*DW +: DW] = value;
        PORT_UPDT[ch] = 1'b1;
        step();
        PORT_UPDT[ch] = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [7:0] a;
        SI_Reset = 1'b1;
        repeat (3) step();
        SI_Reset = 1'b0;
        n_run++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", IRQ); end
        n_run++; if (PORT_CTRL !== '0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", PORT_CTRL); end
        n_run++; if (PORT_INTACK !== '0) begin n_fail++; $display("FAIL reset_intack: got %b want 0", PORT_INTACK); end
        n_run++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL hreadyout: got %b want 1", HREADYOUT); end
        n_run++; if (HRESP !== 1'b0) begin n_fail++; $display("FAIL hresp: got %b want 0", HRESP); end
        n_run++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata: got %h want 0", HRDATA); end
        for (int w = 0; w < 17; w++) begin
            a = 8'(w * 4);
            ahb_read(a, 32'h0, $sformatf("reset_read_%02h", a));
        end
        ahb_read(8'hFC, 32'h0, "unmapped_read");
    endtask

    task automatic test_capture_irq();
        ahb_write(8'h24, 32'h2, 3'b010);
        PORT_INFO[1*DW +: DW] = 32'hCAFE0001;
        PORT_UPDT[1] = 1'b1;
        step();
        n_run++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b want 0", IRQ); end
        step();
        n_run++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", IRQ); end
        PORT_UPDT[1] = 1'b0;
        ahb_read(8'h20, 32'h2, "pending_ch1");
        ahb_read(8'h04, 32'hCAFE0001, "ch1_data");
        n_run++; if (PORT_INTACK !== 4'b0010) begin n_fail++; $display("FAIL intack_ch1: got %b want 0010", PORT_INTACK); end
        step();
        n_run++; if (PORT_INTACK !== 4'b0000) begin n_fail++; $display("FAIL intack_once: got %b want 0000", PORT_INTACK); end
        n_run++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b want 0", IRQ); end
        ahb_read(8'h20, 32'h0, "pending_cleared");
    endtask

    task automatic test_overrun();
        pulse_updt(0, 32'h11);
        pulse_updt(0, 32'h22);
        ahb_read(8'h2C, 32'h1, "overrun_ch0");
        ahb_read(8'h20, 32'h1, "pending_ch0");
        n_run++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b want 0", IRQ); end
        ahb_read(8'h00, 32'h22, "ch0_latest");
        ahb_write(8'h2C, 32'h1, 3'b010);
        ahb_read(8'h2C, 32'h0, "overrun_w1c");
        ahb_read(8'h20, 32'h0, "pending_ch0_cleared");
    endtask

    task automatic test_collision();
        pulse_updt(2, 32'h33);
        exp_q.push_back(32'h33);
        name_q.push_back("collision_old_data");
        PORT_INFO[2*DW +: DW] = 32'h44;
        PORT_UPDT[2] = 1'b1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 8'h08; HSIZE = 3'b010;
        step();
        bus_idle();
        PORT_UPDT[2] = 1'b0;
        sb_check();
        n_run++; if (PORT_INTACK !== 4'b0000) begin n_fail++; $display("FAIL collision_intack: got %b want 0000", PORT_INTACK); end
        ahb_read(8'h20, 32'h4, "collision_pending");
        ahb_read(8'h2C, 32'h0, "collision_no_overrun");
        ahb_read(8'h08, 32'h44, "collision_new_data");
        n_run++; if (PORT_INTACK !== 4'b0100) begin n_fail++; $display("FAIL intack_ch2: got %b want 0100", PORT_INTACK); end
    endtask

    task automatic test_ack();
        pulse_updt(3, 32'h55);
        ahb_write(8'h28, 32'h8, 3'b010);
        n_run++; if (PORT_INTACK !== 4'b1000) begin n_fail++; $display("FAIL ack_intack: got %b want 1000", PORT_INTACK); end
        ahb_read(8'h20, 32'h0, "ack_pending");
        ahb_read(8'h0C, 32'h55, "ack_data_kept");
    endtask

    task automatic test_back_to_back();
        ahb_write(8'h30, 32'hA5, 3'b010);
        ahb_write(8'h34, 32'h3C, 3'b010);
        write_then_read(8'h30, 32'hFF, 3'b001, 8'h30, 32'hA5, "halfword_ignored");
        n_run++; if (PORT_CTRL !== 16'h3CA5) begin n_fail++; $display("FAIL port_ctrl: got %h want 3ca5", PORT_CTRL); end
        write_then_read(8'h34, 32'h1234_565A, 3'b010, 8'h34, 32'h5A, "ctrl1_forward");
        n_run++; if (PORT_CTRL !== 16'h5AA5) begin n_fail++; $display("FAIL port_ctrl_b2b: got %h want 5aa5", PORT_CTRL); end
        write_then_read(8'h24, 32'hFFFF_FFF6, 3'b010, 8'h24, 32'h6, "mask_forward");
        write_then_read(8'h40, 32'hDEAD_BEEF, 3'b010, 8'h40, 32'h0, "unmapped_write");
        ahb_write(8'h24, 32'h2, 3'b010);
    endtask

    task automatic test_reset_abort();
        pulse_updt(1, 32'h77);
        n_run++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b want 1", IRQ); end
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 8'h24; HSIZE = 3'b010;
        step();
        bus_idle();
        HWDATA = 32'hF;
        SI_Reset = 1'b1;
        PORT_UPDT[0] = 1'b1;
        step();
        n_run++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL abort_irq: got %b want 0", IRQ); end
        n_run++; if (PORT_CTRL !== '0) begin n_fail++; $display("FAIL abort_ctrl: got %h want 0", PORT_CTRL); end
        n_run++; if (PORT_INTACK !== '0) begin n_fail++; $display("FAIL abort_intack: got %b want 0", PORT_INTACK); end
        n_run++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL abort_hrdata: got %h want 0", HRDATA); end
        SI_Reset = 1'b0;
        step();
        ahb_read(8'h24, 32'h0, "abort_mask");
        ahb_read(8'h20, 32'h0, "held_updt_no_capture");
        ahb_read(8'h04, 32'h0, "abort_data");
        PORT_UPDT[0] = 1'b0;
        write_then_read(8'h24, 32'h1, 3'b010, 8'h24, 32'h1, "post_reset_mask");
    endtask

    initial begin
        SI_Reset  = 1'b1;
        HREADY    = 1'b1;
        HADDR     = 8'h0;
        HWDATA    = 32'h0;
        PORT_INFO = '0;
        PORT_UPDT = '0;
        bus_idle();
        test_reset();
        test_capture_irq();
        test_overrun();
        test_collision();
        test_ack();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
